hps_reset_sequencer: RTL and testbench

HPS_RESET_SEQUENCER -- requirements
Module: hps_reset_sequencer

---
 rtl/hps_reset_sequencer_if.sv | 32 +++
 rtl/hps_reset_sequencer.sv | 163 ++++++++++++++++
 tb/tb_hps_reset_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hps_reset_sequencer_if.sv
// Bundles the reset request inputs and the HPS-facing reset outputs of the
// reset sequencer. The slave modport is the sequencer itself; the master
// modport is whatever raises requests and watches the results.
interface hps_reset_sequencer_if;
    logic [2:0] req;
    logic       cold_rst_req_n;
    logic       warm_rst_req_n;
    logic       debug_rst_req_n;
    logic       busy;
    logic [2:0] pending;
    logic       done;

    modport master (
        output req,
        input  cold_rst_req_n,
        input  warm_rst_req_n,
        input  debug_rst_req_n,
        input  busy,
        input  pending,
        input  done
    );

    modport slave (
        input  req,
        output cold_rst_req_n,
        output warm_rst_req_n,
        output debug_rst_req_n,
        output busy,
        output pending,
        output done
    );
endinterface

// File: rtl/hps_reset_sequencer.sv
// HPS reset sequencer: turns level requests for cold, warm and debug resets
// into fixed-length active-low pulses. Requests are edge-detected and
// latched. They are served one at a time in fixed priority order
// (cold > warm > debug), with a holdoff gap after every pulse.
module hps_reset_sequencer #(
    parameter int COLD_LEN  = 6,
    parameter int WARM_LEN  = 2,
    parameter int DEBUG_LEN = 32,
    parameter int GAP_LEN   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hps_reset_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // Counter reload values. The counter counts down to zero, so these are
    // one less than the desired number of cycles.
    localparam logic [5:0] COLD_CNT  = 6'(COLD_LEN - 1);
    localparam logic [5:0] WARM_CNT  = 6'(WARM_LEN - 1);
    localparam logic [5:0] DEBUG_CNT = 6'(DEBUG_LEN - 1);
    localparam logic [5:0] GAP_CNT   = 6'(GAP_LEN - 1);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [2:0] prev_q;
    logic [2:0] pending_q, pending_d;
    logic [2:0] active_q, active_d;
    logic [2:0] out_n_q, out_n_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [2:0] edges;
    logic [2:0] work;
    logic [2:0] grant;
    logic [5:0] grant_cnt;

    // Rising-edge detect per request bit, plus the combined set of requests
    // the arbiter may choose from this cycle (latched ones and fresh edges).
    always_comb begin
        edges = bus.req & ~prev_q;
        work  = pending_q | edges;
    end

    // Fixed-priority arbiter and the pulse length that goes with the winner.
    always_comb begin
        grant     = 3'b000;
        grant_cnt = COLD_CNT;
        if (work[0]) begin
            grant     = 3'b001;
            grant_cnt = COLD_CNT;
        end else if (work[1]) begin
            grant     = 3'b010;
            grant_cnt = WARM_CNT;
        end else if (work[2]) begin
            grant     = 3'b100;
            grant_cnt = DEBUG_CNT;
        end
    end

    // Next-state logic. Leaving HOLDOFF with work waiting goes straight into
    // the next pulse, so back-to-back pulses are separated by exactly the gap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        pending_d = work;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|work) begin
                    state_d   = PULSE;
                    active_d  = grant;
                    cnt_d     = grant_cnt;
                    pending_d = work & ~grant;
                end
            end

            PULSE: begin
                if (cnt_q == 6'd0) begin
                    state_d  = HOLDOFF;
                    cnt_d    = GAP_CNT;
                    active_d = 3'b000;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end

            HOLDOFF: begin
                if (cnt_q == 6'd0) begin
                    if (|work) begin
                        state_d   = PULSE;
                        active_d  = grant;
                        cnt_d     = grant_cnt;
                        pending_d = work & ~grant;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = 6'd0;
                active_d  = 3'b000;
                pending_d = 3'b000;
            end
        endcase
    end

    // Output decode from the next state so the outputs can be registered.
    // Only the granted line is ever low, which keeps the lines mutually
    // exclusive.
    always_comb begin
        out_n_d = 3'b111;
        busy_d  = (state_d != IDLE);
        if (state_d == PULSE) begin
            out_n_d = ~active_d;
        end
    end

    // State, counter, request history and registered outputs. On reset the
    // request history reads as all-high, so a request already held high
    // when reset releases is not taken as a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            prev_q    <= 3'b111;
            pending_q <= 3'b000;
            active_q  <= 3'b000;
            out_n_q   <= 3'b111;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= bus.req;
            pending_q <= pending_d;
            active_q  <= active_d;
            out_n_q   <= out_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.cold_rst_req_n  = out_n_q[0];
    assign bus.warm_rst_req_n  = out_n_q[1];
    assign bus.debug_rst_req_n = out_n_q[2];
    assign bus.busy            = busy_q;
    assign bus.pending         = pending_q;
    assign bus.done            = done_q;

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Testbench for hps_reset_sequencer. A monitor records every completed pulse
// (type, first low cycle, length, done seen on the first high cycle) into an
// observed queue. The directed sequence pushes the pulses it expects into a
// second queue and compares the two. A second instance with short lengths
// covers the minimum-length case.
module tb_hps_reset_sequencer;

    typedef struct {
        int   kind;
        int   start;
        int   len;
        logic done;
    } pulse_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   low_start [3];
    pulse_t exp_q [$];
    pulse_t obs_q [$];

    hps_reset_sequencer_if bus ();
    hps_reset_sequencer_if fbus ();

    hps_reset_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    hps_reset_sequencer #(
        .COLD_LEN (1),
        .GAP_LEN  (1)
    ) u_fast (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fbus.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter: cycle k is the period following the k-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor on the falling edge; an in-flight pulse is dropped when
    // reset is asserted.
    always @(negedge clk) begin
        logic [2:0] outs;
        outs = {bus.debug_rst_req_n, bus.warm_rst_req_n, bus.cold_rst_req_n};
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                low_start[k] = -1;
            end else if (outs[k] == 1'b0 && low_start[k] < 0) begin
                low_start[k] = cyc;
            end else if (outs[k] == 1'b1 && low_start[k] >= 0) begin
                obs_q.push_back('{k, low_start[k], cyc - low_start[k], bus.done});
                low_start[k] = -1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] value);
        bus.req = value;
    endtask

    task automatic expect_pulse(input int kind, input int start, input int len);
        exp_q.push_back('{kind, start, len, 1'b1});
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        check_output("idle_within_budget", bus.busy, 1'b0);
    endtask

    task automatic compare_pulses(input string tag);
        pulse_t e, o;
        check_output({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check_output({tag, "_kind"}, o.kind, e.kind);
            check_output({tag, "_start"}, o.start, e.start);
            check_output({tag, "_len"}, o.len, e.len);
            check_output({tag, "_done"}, o.done, e.done);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int c;
        for (int k = 0; k < 3; k++) low_start[k] = -1;
        rst_n    = 1'b0;
        bus.req  = 3'b000;
        fbus.req = 3'b000;

        // Reset state.
        step(3);
        check_output("rst_cold", bus.cold_rst_req_n, 1'b1);
        check_output("rst_warm", bus.warm_rst_req_n, 1'b1);
        check_output("rst_debug", bus.debug_rst_req_n, 1'b1);
        check_output("rst_busy", bus.busy, 1'b0);
        check_output("rst_pending", bus.pending, 3'b000);
        check_output("rst_done", bus.done, 1'b0);
        rst_n = 1'b1;
        step(2);

        // Single warm request raised in cycle 10.
        step_to(10);
        c = cyc;
        apply_stimulus(3'b010);
        expect_pulse(1, c + 1, 2);
        step_to(c + 6);
        check_output("warm_busy_holdoff", bus.busy, 1'b1);
        step_to(c + 7);
        check_output("warm_busy_released", bus.busy, 1'b0);
        apply_stimulus(3'b000);
        compare_pulses("warm");

        // Simultaneous requests are served cold, warm, debug.
        step(2);
        c = cyc;
        apply_stimulus(3'b111);
        expect_pulse(0, c + 1, 6);
        expect_pulse(1, c + 11, 2);
        expect_pulse(2, c + 17, 32);
        step_to(c + 2);
        check_output("simul_pending_cold", bus.pending, 3'b110);
        step_to(c + 12);
        check_output("simul_pending_warm", bus.pending, 3'b100);
        step_to(c + 18);
        check_output("simul_pending_debug", bus.pending, 3'b000);
        wait_idle(100);
        apply_stimulus(3'b000);
        compare_pulses("simul");

        // Two same-type edges during a debug pulse merge into one retrigger.
        step(2);
        c = cyc;
        apply_stimulus(3'b100);
        expect_pulse(2, c + 1, 32);
        expect_pulse(2, c + 37, 32);
        step_to(c + 5);
        apply_stimulus(3'b000);
        step_to(c + 7);
        apply_stimulus(3'b100);
        step_to(c + 9);
        apply_stimulus(3'b000);
        step_to(c + 11);
        apply_stimulus(3'b100);
        step_to(c + 12);
        check_output("retrig_pending", bus.pending, 3'b100);
        wait_idle(150);
        compare_pulses("retrig");

        // A cold edge does not preempt a running debug pulse.
        apply_stimulus(3'b000);
        step(2);
        c = cyc;
        apply_stimulus(3'b100);
        expect_pulse(2, c + 1, 32);
        expect_pulse(0, c + 37, 6);
        step_to(c + 5);
        apply_stimulus(3'b101);
        step_to(c + 10);
        check_output("nopre_pending_early", bus.pending[0], 1'b1);
        check_output("nopre_debug_low", bus.debug_rst_req_n, 1'b0);
        step_to(c + 32);
        check_output("nopre_pending_last", bus.pending[0], 1'b1);
        check_output("nopre_cold_high", bus.cold_rst_req_n, 1'b1);
        step_to(c + 36);
        check_output("nopre_pending_gap", bus.pending[0], 1'b1);
        wait_idle(100);
        compare_pulses("nopre");

        // Reset in the third cold cycle aborts the pulse; a held request
        // does not restart it after release.
        apply_stimulus(3'b000);
        step(2);
        c = cyc;
        apply_stimulus(3'b001);
        step_to(c + 3);
        check_output("abort_cold_low", bus.cold_rst_req_n, 1'b0);
        rst_n = 1'b0;
        #1;
        check_output("abort_cold_high", bus.cold_rst_req_n, 1'b1);
        check_output("abort_warm_high", bus.warm_rst_req_n, 1'b1);
        check_output("abort_debug_high", bus.debug_rst_req_n, 1'b1);
        check_output("abort_busy", bus.busy, 1'b0);
        check_output("abort_pending", bus.pending, 3'b000);
        step(2);
        rst_n = 1'b1;
        step(20);
        check_output("held_no_pulse_busy", bus.busy, 1'b0);
        check_output("held_no_pulse_cold", bus.cold_rst_req_n, 1'b1);
        compare_pulses("held");

        // Minimum lengths on the fast instance.
        c = cyc;
        fbus.req = 3'b001;
        step_to(c + 1);
        check_output("fast_cold_low", fbus.cold_rst_req_n, 1'b0);
        check_output("fast_busy_pulse", fbus.busy, 1'b1);
        step_to(c + 2);
        check_output("fast_cold_high", fbus.cold_rst_req_n, 1'b1);
        check_output("fast_done", fbus.done, 1'b1);
        check_output("fast_busy_gap", fbus.busy, 1'b1);
        step_to(c + 3);
        check_output("fast_idle", fbus.busy, 1'b0);
        check_output("fast_done_clear", fbus.done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
